// File: rtl/core_pkg.sv
// Shared register-file geometry and writeback FSM encoding for the core.
package core_pkg;
    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 16;

    typedef enum logic {
        WB_RUN  = 1'b0,
        WB_HELD = 1'b1
    } wb_state_t;
endpackage

// File: rtl/load_scoreboard.sv
// In-flight load tracking: pending-destination bits, outstanding-load count and hazard queries.
module load_scoreboard
    import core_pkg::*;
#(
    parameter int MAX_LOADS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    output logic                 pend_rs1,
    output logic                 pend_rs2,
    output logic                 pend_rd,
    output logic                 ld_full
);
    localparam logic [1:0] MAX_CNT = 2'(MAX_LOADS);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_nxt;
    logic [1:0]          ld_cnt;

    // Clear first so a same-cycle set of the same bit wins; r0 is never tracked.
    always_comb begin
        pend_nxt = pend;
        if (clr_en) pend_nxt[clr_idx] = 1'b0;
        if (set_en && set_idx != '0) pend_nxt[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= '0;
            ld_cnt <= '0;
        end else begin
            pend <= pend_nxt;
            case ({set_en, clr_en})
                2'b10:   ld_cnt <= ld_cnt + 2'd1;
                2'b01:   if (ld_cnt != 2'd0) ld_cnt <= ld_cnt - 2'd1;
                default: ld_cnt <= ld_cnt;
            endcase
        end
    end

    assign pend_rs1 = pend[rs1];
    assign pend_rs2 = pend[rs2];
    assign pend_rd  = pend[rd];
    assign ld_full  = (ld_cnt == MAX_CNT);
endmodule

// File: rtl/wb_scheduler.sv
// Register-file write-port arbiter and issue hazard checker (loads beat ALU results).
// Optional macro WB_SCHED_BYPASS_EN lets an op consume returning load data in the same cycle.
module wb_scheduler
    import core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MAX_LOADS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic                 is_alu_op,
    input  logic                 is_load,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic [XLEN-1:0]      alu_result,
    output logic                 lsu_req_valid,
    input  logic                 lsu_req_ready,
    input  logic                 ld_valid,
    input  logic [REG_IDX_W-1:0] ld_rd,
    input  logic [XLEN-1:0]      ld_data,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 rs1_ld_bypass,
    output logic                 rs2_ld_bypass,
    output logic                 stall
);
    wb_state_t              state, state_nxt;
    logic [REG_IDX_W-1:0]   hold_rd;
    logic [XLEN-1:0]        hold_data;
    logic                   pend_rs1, pend_rs2, pend_rd, ld_full;
    logic                   byp1, byp2;
    logic                   core_ok, ld_ok, load_acc, alu_fire, hold_load;

`ifdef WB_SCHED_BYPASS_EN
    assign byp1 = ld_valid && (ld_rd == rs1) && (rs1 != '0);
    assign byp2 = ld_valid && (ld_rd == rs2) && (rs2 != '0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    load_scoreboard #(.MAX_LOADS(MAX_LOADS)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (load_acc),
        .set_idx  (rd),
        .clr_en   (ld_valid),
        .clr_idx  (ld_rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .pend_rs1 (pend_rs1),
        .pend_rs2 (pend_rs2),
        .pend_rd  (pend_rd),
        .ld_full  (ld_full)
    );

    // Checks that do not involve the LSU handshake; lsu_req_valid depends only on these.
    assign core_ok = !(pend_rs1 && !byp1) && !(pend_rs2 && !byp2)
                   && !((is_alu_op || is_load) && pend_rd)
                   && !(state == WB_HELD && (hold_rd == rs1 || hold_rd == rs2 || is_alu_op));
    assign ld_ok   = !ld_full || ld_valid;

    assign issue_ready   = rst_n && core_ok && !(is_load && (!ld_ok || !lsu_req_ready));
    assign lsu_req_valid = rst_n && issue_valid && is_load && core_ok && ld_ok;
    assign load_acc      = lsu_req_valid && lsu_req_ready;
    assign alu_fire      = issue_valid && issue_ready && is_alu_op;
    assign hold_load     = (state == WB_RUN) && alu_fire && ld_valid && (rd != '0);
    assign stall         = issue_valid && !issue_ready;
    assign rs1_ld_bypass = issue_valid && byp1;
    assign rs2_ld_bypass = issue_valid && byp2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WB_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_RUN:  if (hold_load) state_nxt = WB_HELD;
            WB_HELD: if (!ld_valid) state_nxt = WB_RUN;
            default: state_nxt = WB_RUN;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (ld_valid) begin
            rf_we    = (ld_rd != '0);
            rf_waddr = ld_rd;
            rf_wdata = ld_data;
        end else if (state == WB_HELD) begin
            rf_we    = 1'b1;
            rf_waddr = hold_rd;
            rf_wdata = hold_data;
        end else if (alu_fire) begin
            rf_we    = (rd != '0);
            rf_waddr = rd;
            rf_wdata = alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_rd   <= '0;
            hold_data <= '0;
        end else if (hold_load) begin
            hold_rd   <= rd;
            hold_data <= alu_result;
        end
    end
endmodule

// File: tb/tb_wb_scheduler.sv
// Table-driven plus hand-sequenced bench; register writes are checked in order against a queue.
module tb_wb_scheduler;
    import core_pkg::*;

`ifdef WB_SCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, is_alu_op, is_load, lsu_req_ready, ld_valid;
    logic [3:0]  rs1, rs2, rd, ld_rd;
    logic [31:0] alu_result, ld_data;
    logic        issue_ready, lsu_req_valid, rf_we, rs1_ld_bypass, rs2_ld_bypass, stall;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;
    logic [35:0] wq[$];

    typedef struct {
        logic        iv, alu, ld;
        logic [3:0]  rs1, rs2, rd;
        logic [31:0] ares;
        logic        lrdy, lv;
        logic [3:0]  lrd;
        logic [31:0] ldat;
        logic        e_ready, e_lreq, e_we;
        logic [3:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl[18];

    wb_scheduler #(.XLEN(32), .MAX_LOADS(2)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .is_alu_op(is_alu_op), .is_load(is_load), .rs1(rs1), .rs2(rs2), .rd(rd),
        .alu_result(alu_result), .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rs1_ld_bypass(rs1_ld_bypass),
        .rs2_ld_bypass(rs2_ld_bypass), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Write-port scoreboard: every enabled write must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got r%0d=%0h expected no write", rf_waddr, rf_wdata);
            end else begin
                chk("wr_order", {rf_waddr, rf_wdata}, wq.pop_front());
            end
        end
    end

    function automatic vec_t mk(logic iv, logic alu, logic ld, logic [3:0] r1, logic [3:0] r2,
                                logic [3:0] d, logic [31:0] ares, logic lrdy, logic lv,
                                logic [3:0] lrd, logic [31:0] ldat, logic er, logic el,
                                logic ew, logic [3:0] ewa, logic [31:0] ewd);
        vec_t v;
        v.iv = iv; v.alu = alu; v.ld = ld; v.rs1 = r1; v.rs2 = r2; v.rd = d; v.ares = ares;
        v.lrdy = lrdy; v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.e_ready = er; v.e_lreq = el; v.e_we = ew; v.e_waddr = ewa; v.e_wdata = ewd;
        return v;
    endfunction

    function automatic vec_t idle_lv(logic [3:0] lrd, logic [31:0] ldat);
        return mk(0,0,0, 0,0,0, 0, 0, 1, lrd, ldat, 1, 0, lrd != 0, lrd, ldat);
    endfunction

    // Called at posedge+1: drive, compare at the falling edge, return at next posedge+1.
    task automatic apply(input vec_t v, input string nm);
        logic eb1, eb2;
        issue_valid = v.iv; is_alu_op = v.alu; is_load = v.ld;
        rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; alu_result = v.ares;
        lsu_req_ready = v.lrdy; ld_valid = v.lv; ld_rd = v.lrd; ld_data = v.ldat;
        if (v.e_we) wq.push_back({v.e_waddr, v.e_wdata});
        eb1 = BYP && v.iv && v.lv && v.lrd == v.rs1 && v.rs1 != 0;
        eb2 = BYP && v.iv && v.lv && v.lrd == v.rs2 && v.rs2 != 0;
        @(negedge clk);
        chk({nm, ".ready"}, 36'(issue_ready), 36'(v.e_ready));
        chk({nm, ".lreq"},  36'(lsu_req_valid), 36'(v.e_lreq));
        chk({nm, ".stall"}, 36'(stall), 36'(v.iv && !v.e_ready));
        chk({nm, ".we"},    36'(rf_we), 36'(v.e_we));
        chk({nm, ".byp"},   36'({rs1_ld_bypass, rs2_ld_bypass}), 36'({eb1, eb2}));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string nm);
        @(negedge clk);
        chk({nm, ".ready"}, 36'(issue_ready), 36'(0));
        chk({nm, ".we"}, 36'({rf_we, rf_waddr, rf_wdata}), 36'(0));
        chk({nm, ".lreq"}, 36'({lsu_req_valid, stall, rs1_ld_bypass, rs2_ld_bypass}), 36'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0, 0,0,0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        issue_valid = 0; is_alu_op = 0; is_load = 0; rs1 = 0; rs2 = 0; rd = 0;
        alu_result = 0; lsu_req_ready = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
        @(posedge clk); #1;
        reset_checks("reset");
        rst_n = 1'b1;

        //            iv al ld rs1 rs2 rd  ares         rdy lv lrd ldat   rdy lrq we wa  wd
        tbl[0]  = mk(0, 0, 0, 0,  0,  0,  0,            0,  0, 0,  0,     1,  0,  0, 0,  0);
        tbl[1]  = mk(1, 1, 0, 1,  2,  3,  32'hAAAA0001, 0,  0, 0,  0,     1,  0,  1, 3,  32'hAAAA0001);
        tbl[2]  = mk(1, 1, 0, 1,  2,  0,  32'hDEAD,     0,  0, 0,  0,     1,  0,  0, 0,  0);
        tbl[3]  = mk(1, 0, 0, 1,  2,  5,  32'h55,       0,  0, 0,  0,     1,  0,  0, 0,  0);
        tbl[4]  = mk(1, 0, 1, 1,  0,  6,  0,            0,  0, 0,  0,     0,  1,  0, 0,  0);
        tbl[5]  = mk(1, 0, 1, 1,  0,  6,  0,            1,  0, 0,  0,     1,  1,  0, 0,  0);
        tbl[6]  = mk(1, 1, 0, 6,  0,  8,  32'h88,       0,  0, 0,  0,     0,  0,  0, 0,  0);
        tbl[7]  = mk(1, 0, 0, 6,  0,  0,  0,            0,  1, 6,  32'h66, BYP, 0, 1, 6,  32'h66);
        tbl[8]  = mk(1, 1, 0, 6,  0,  8,  32'h88,       0,  0, 0,  0,     1,  0,  1, 8,  32'h88);
        tbl[9]  = idle_lv(9, 32'h99);
        tbl[10] = idle_lv(0, 32'h1);
        tbl[11] = mk(1, 0, 1, 0,  0,  0,  0,            1,  0, 0,  0,     1,  1,  0, 0,  0);
        tbl[12] = mk(1, 1, 0, 0,  0,  11, 32'hB,        0,  0, 0,  0,     1,  0,  1, 11, 32'hB);
        tbl[13] = mk(1, 0, 1, 0,  0,  12, 0,            1,  0, 0,  0,     1,  1,  0, 0,  0);
        tbl[14] = mk(1, 0, 1, 0,  0,  13, 0,            1,  0, 0,  0,     0,  0,  0, 0,  0);
        tbl[15] = mk(1, 0, 1, 0,  0,  13, 0,            1,  1, 0,  32'h5, 1,  1,  0, 0,  0);
        tbl[16] = idle_lv(12, 32'hC);
        tbl[17] = idle_lv(13, 32'hD);
        for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Load-use: consumer waits two cycles, then issues with bypass or one cycle later.
        apply(mk(1,0,1, 0,0,5, 0, 1, 0,0,0, 1,1,0,0,0), "lu.load");
        apply(mk(1,1,0, 5,0,1, 32'h111, 0, 0,0,0, 0,0,0,0,0), "lu.wait0");
        apply(mk(1,1,0, 5,0,1, 32'h111, 0, 0,0,0, 0,0,0,0,0), "lu.wait1");
        apply(mk(1,1,0, 5,0,1, 32'h111, 0, 1,5,32'h55, BYP,0,1,5,32'h55), "lu.ret");
        apply(mk(!BYP,!BYP,0, BYP ? 4'd0 : 4'd5,0,BYP ? 4'd0 : 4'd1, 32'h111, 0, 0,0,0,
                 1,0,1,1,32'h111), "lu.alu");

        // ALU write collides with load return: load first, held ALU next, then RUN again.
        apply(mk(1,1,0, 1,2,3, 32'h1234, 0, 1,7,32'h77, 1,0,1,7,32'h77), "hold.enter");
        apply(mk(1,1,0, 0,0,2, 32'h22, 0, 0,0,0, 0,0,1,3,32'h1234), "hold.drain");
        apply(mk(1,1,0, 0,0,2, 32'h22, 0, 0,0,0, 1,0,1,2,32'h22), "hold.run");

        // Held entry survives three consecutive load returns.
        apply(mk(1,1,0, 0,0,4, 32'h4444, 0, 1,9,32'h90, 1,0,1,9,32'h90), "hold3.enter");
        for (int k = 0; k < 3; k++)
            apply(mk(1,1,0, 0,0,10, 32'hA0, 0, 1,4'(11+k),32'hB0+k, 0,0,1,4'(11+k),32'hB0+k),
                  $sformatf("hold3.lv%0d", k));
        apply(mk(1,1,0, 0,0,10, 32'hA0, 0, 0,0,0, 0,0,1,4,32'h4444), "hold3.drain");
        apply(mk(1,1,0, 0,0,10, 32'hA0, 0, 0,0,0, 1,0,1,10,32'hA0), "hold3.run");

        // Outstanding-load limit: third load waits for the first return.
        apply(mk(1,0,1, 0,0,1, 0, 1, 0,0,0, 1,1,0,0,0), "max.l1");
        apply(mk(1,0,1, 0,0,2, 0, 1, 0,0,0, 1,1,0,0,0), "max.l2");
        apply(mk(1,0,1, 0,0,3, 0, 1, 0,0,0, 0,0,0,0,0), "max.l3a");
        apply(mk(1,0,1, 0,0,3, 0, 1, 0,0,0, 0,0,0,0,0), "max.l3b");
        apply(mk(1,0,1, 0,0,3, 0, 1, 1,1,32'h10, 1,1,1,1,32'h10), "max.l3go");
        apply(mk(1,0,1, 0,0,4, 0, 1, 0,0,0, 0,0,0,0,0), "max.full");
        apply(idle_lv(2, 32'h20), "max.r2");
        apply(idle_lv(3, 32'h30), "max.r3");

        // WAW: ALU to a pending load destination waits until the load has written.
        apply(mk(1,0,1, 0,0,4, 0, 1, 0,0,0, 1,1,0,0,0), "waw.load");
        apply(mk(1,1,0, 0,0,4, 32'h4A, 0, 0,0,0, 0,0,0,0,0), "waw.wait");
        apply(mk(1,1,0, 0,0,4, 32'h4A, 0, 1,4,32'h40, 0,0,1,4,32'h40), "waw.ret");
        apply(mk(1,1,0, 0,0,4, 32'h4A, 0, 0,0,0, 1,0,1,4,32'h4A), "waw.alu");

        // Reset while HELD with loads pending.
        apply(mk(1,0,1, 0,0,5, 0, 1, 0,0,0, 1,1,0,0,0), "rst.l5");
        apply(mk(1,0,1, 0,0,6, 0, 1, 0,0,0, 1,1,0,0,0), "rst.l6");
        apply(mk(1,1,0, 0,0,7, 32'h77, 0, 1,12,32'hC, 1,0,1,12,32'hC), "rst.hold");
        issue_valid = 0; is_alu_op = 0; is_load = 0; rs1 = 0; rs2 = 0; rd = 0;
        lsu_req_ready = 0; ld_valid = 0; ld_rd = 0;
        rst_n = 1'b0;
        reset_checks("rst.mid0");
        reset_checks("rst.mid1");
        rst_n = 1'b1;
        apply(mk(1,1,0, 5,6,7, 32'h700, 0, 0,0,0, 1,0,1,7,32'h700), "rst.alu");
        apply(mk(1,0,1, 0,0,5, 0, 1, 0,0,0, 1,1,0,0,0), "rst.n5");
        apply(mk(1,0,1, 0,0,6, 0, 1, 0,0,0, 1,1,0,0,0), "rst.n6");
        apply(mk(1,0,1, 0,0,8, 0, 1, 0,0,0, 0,0,0,0,0), "rst.full");
        apply(idle_lv(5, 32'h50), "rst.r5");
        apply(idle_lv(6, 32'h60), "rst.r6");
        apply(idle, "final.idle");

        chk("wr_queue_empty", 36'(wq.size()), 36'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
